// File: rtl/sisc_pkg.sv
// Shared types for the SISC memory path: arbiter FSM encoding, requester IDs
// and default bus widths.
package sisc_pkg;

  localparam int SISC_ADDR_W = 16;
  localparam int SISC_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
  endfunction

endpackage

// File: rtl/sisc_rr_arb2.sv
// Two-requester round-robin picker: on a tie the port that was not granted
// last wins. Purely combinational; the caller registers the result.
module sisc_rr_arb2
  import sisc_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_e      last_i,
  output port_e      grant_o,
  output logic       valid_o
);

  // Bit 0 is the fetch request, bit 1 the data request.
  always_comb begin
    grant_o = PORT_FETCH;
    valid_o = 1'b0;
    case (req_i)
      2'b01: begin
        grant_o = PORT_FETCH;
        valid_o = 1'b1;
      end
      2'b10: begin
        grant_o = PORT_DATA;
        valid_o = 1'b1;
      end
      2'b11: begin
        grant_o = other_port(last_i);
        valid_o = 1'b1;
      end
      default: begin
        grant_o = PORT_FETCH;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sisc_mem_arb.sv
// Single-port SISC memory sequencer shared between instruction fetch and data
// access; one access in flight, all outputs registered.
module sisc_mem_arb
  import sisc_pkg::*;
#(
  parameter int ADDR_W  = SISC_ADDR_W,
  parameter int DATA_W  = SISC_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT);

  arb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  port_e             last_q, last_d;
  port_e             port_q, port_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  port_e             gnt_port;
  logic              gnt_valid;

  sisc_rr_arb2 u_rr (
    .req_i   ({d_req, if_req}),
    .last_i  (last_q),
    .grant_o (gnt_port),
    .valid_o (gnt_valid)
  );

  // The memory address/data registers double as the request latch, so they
  // only move when a grant is taken and hold their value otherwise.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    port_d      = port_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = ST_ISSUE;
          port_d  = gnt_port;
          last_d  = gnt_port;
          if (gnt_port == PORT_DATA) begin
            we_d        = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            we_d       = 1'b0;
            mem_addr_d = if_addr;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          if (port_q == PORT_DATA) begin
            d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so they appear in the same
  // cycle the FSM occupies ISSUE / RESP, while still coming from flops.
  always_comb begin
    mem_en_d = (state_d == ST_ISSUE);
    mem_we_d = (state_d == ST_ISSUE) && we_d;
    if_ack_d = (state_d == ST_RESP) && (port_d == PORT_FETCH);
    d_ack_d  = (state_d == ST_RESP) && (port_d == PORT_DATA);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      last_q      <= PORT_FETCH;
      port_q      <= PORT_FETCH;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      port_q      <= port_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Bench for sisc_mem_arb: instance 0 uses MEM_LAT=1, instance 1 MEM_LAT=3,
// each attached to a behavioural memory with the matching read latency.
module tb_sisc_mem_arb;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam logic [DW-1:0] JUNK = 32'h5A5A_5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst [2];
  logic          if_req [2];
  logic [AW-1:0] if_addr [2];
  logic          if_ack [2];
  logic [DW-1:0] if_rdata [2];
  logic          d_req [2];
  logic          d_we [2];
  logic [AW-1:0] d_addr [2];
  logic [DW-1:0] d_wdata [2];
  logic          d_ack [2];
  logic [DW-1:0] d_rdata [2];
  logic          mem_en [2];
  logic          mem_we [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy [2];

  logic [DW-1:0] mem [2][256];
  logic [DW-1:0] pipe [2][15];
  logic          mem_clr = 1'b0;
  logic          poke_en = 1'b0;
  int            poke_k = 0;
  logic [7:0]    poke_a = 8'd0;
  logic [DW-1:0] poke_v = 32'd0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? LAT0 : LAT1;
    sisc_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) u_dut (
      .clk(clk), .rst(rst[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );
    assign mem_rdata[g] = pipe[g][L-1];
  end

  // Memory: read data valid L cycles after the mem_en cycle, junk otherwise.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      for (int i = 14; i > 0; i--) pipe[g][i] <= pipe[g][i-1];
      pipe[g][0] <= JUNK;
      if (mem_en[g] && mem_we[g]) mem[g][mem_addr[g][7:0]] <= mem_wdata[g];
      else if (mem_en[g]) pipe[g][0] <= mem[g][mem_addr[g][7:0]];
      if (poke_en && poke_k == g) mem[g][poke_a] <= poke_v;
      if (mem_clr) for (int a = 0; a < 256; a++) mem[g][a] <= '0;
    end
  end

  typedef struct {
    int            k;
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          poke;
    logic [DW-1:0] pv;
    int            exp_ack;
    logic [DW-1:0] exp_rd;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] model_mem [2][256];

  int w_dack, w_iack, w_nd, w_ni, w_men_n, w_men0, w_men1, w_ovl;
  logic [AW-1:0] w_addr0;
  logic          w_we0;
  logic [DW-1:0] w_wd0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [4:0] outs_ctl(input int k);
    return {if_ack[k], d_ack[k], mem_en[k], mem_we[k], busy[k]};
  endfunction

  task automatic poke(input int k, input logic [7:0] a, input logic [DW-1:0] v);
    poke_en = 1'b1; poke_k = k; poke_a = a; poke_v = v;
    tick();
    poke_en = 1'b0;
    model_mem[k][a] = v;
  endtask

  task automatic do_reset(input int k);
    if_req[k] = 1'b0; d_req[k] = 1'b0;
    rst[k] = 1'b1;
    tick(); tick();
    rst[k] = 1'b0;
  endtask

  // Observe ncyc cycles after the current one (cycle 0); requesters drop on ack.
  task automatic watch(input int k, input int ncyc, input int raise_if_at, input logic [AW-1:0] raise_addr);
    w_dack = -1; w_iack = -1; w_nd = 0; w_ni = 0; w_men_n = 0; w_men0 = -1; w_men1 = -1; w_ovl = 0;
    w_addr0 = '0; w_we0 = 1'b0; w_wd0 = '0;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (mem_en[k]) begin
        if (w_men_n == 0) begin
          w_men0 = c; w_addr0 = mem_addr[k]; w_we0 = mem_we[k]; w_wd0 = mem_wdata[k];
        end else if (w_men_n == 1) begin
          w_men1 = c;
        end
        w_men_n++;
      end
      if (if_ack[k] && d_ack[k]) w_ovl++;
      if (d_ack[k]) begin w_nd++; if (w_dack < 0) w_dack = c; d_req[k] = 1'b0; end
      if (if_ack[k]) begin w_ni++; if (w_iack < 0) w_iack = c; if_req[k] = 1'b0; end
      if (c == raise_if_at) begin if_req[k] = 1'b1; if_addr[k] = raise_addr; end
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [DW-1:0] p_if, p_d, exp_if, exp_d;
    if (v.poke) poke(v.k, v.addr[7:0], v.pv);
    p_if = if_rdata[v.k]; p_d = d_rdata[v.k];
    if (v.port) begin
      d_req[v.k] = 1'b1; d_we[v.k] = v.we; d_addr[v.k] = v.addr; d_wdata[v.k] = v.wdata;
    end else begin
      if_req[v.k] = 1'b1; if_addr[v.k] = v.addr;
    end
    watch(v.k, v.exp_ack + 4, -1, '0);
    if (v.we) model_mem[v.k][v.addr[7:0]] = v.wdata;
    exp_if = (!v.port) ? v.exp_rd : p_if;
    exp_d  = (v.port && !v.we) ? v.exp_rd : p_d;
    chk($sformatf("vec%0d ack_cycle", i), v.port ? w_dack : w_iack, v.exp_ack);
    chk($sformatf("vec%0d ack_count", i), v.port ? w_nd : w_ni, 1);
    chk($sformatf("vec%0d other_ack", i), v.port ? w_ni : w_nd, 0);
    chk($sformatf("vec%0d mem_en_count", i), w_men_n, 1);
    chk($sformatf("vec%0d mem_en_cycle", i), w_men0, 1);
    chk($sformatf("vec%0d mem_addr", i), w_addr0, v.addr);
    chk($sformatf("vec%0d mem_we", i), w_we0, v.we);
    if (v.we) chk($sformatf("vec%0d mem_wdata", i), w_wd0, v.wdata);
    chk($sformatf("vec%0d rdata", i), {if_rdata[v.k], d_rdata[v.k]}, {exp_if, exp_d});
  endtask

  vec_t vecs [8];
  vec_t v5;
  bit            act [2];
  logic [AW-1:0] rq_addr [2];
  logic          rq_we [2];
  logic [DW-1:0] rq_wd [2];
  logic [DW-1:0] e_rd [2];

  initial begin
    int n, m_free, m_last, p, g_grant, g_issue, g_ack, g_port;
    logic g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd, g_rd, v6a, v6b;
    logic [4:0] exp_ctl;

    vecs[0] = '{0, 1'b0, 1'b0, 16'h0010, 32'h0,         1'b1, 32'h8100_0003, 3, 32'h8100_0003};
    vecs[1] = '{0, 1'b1, 1'b1, 16'h0020, 32'hDEAD_BEEF, 1'b0, 32'h0,         2, 32'h0};
    vecs[2] = '{0, 1'b1, 1'b0, 16'h0020, 32'h0,         1'b0, 32'h0,         3, 32'hDEAD_BEEF};
    vecs[3] = '{1, 1'b1, 1'b0, 16'h0005, 32'h0,         1'b1, 32'h1234_5678, 5, 32'h1234_5678};
    vecs[4] = '{1, 1'b0, 1'b0, 16'h00FF, 32'h0,         1'b1, 32'hA5A5_0F0F, 5, 32'hA5A5_0F0F};
    vecs[5] = '{1, 1'b1, 1'b1, 16'h0040, 32'h0BAD_F00D, 1'b0, 32'h0,         2, 32'h0};
    vecs[6] = '{1, 1'b1, 1'b0, 16'h0040, 32'h0,         1'b0, 32'h0,         5, 32'h0BAD_F00D};
    vecs[7] = '{0, 1'b0, 1'b0, 16'h0040, 32'h0,         1'b1, 32'h7777_0001, 3, 32'h7777_0001};

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0;
      d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      for (int a = 0; a < 256; a++) model_mem[k][a] = '0;
    end
    mem_clr = 1'b1;
    tick(); tick();
    mem_clr = 1'b0;
    rst[0] = 1'b0; rst[1] = 1'b0;

    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset ctl%0d", k), outs_ctl(k), 5'd0);
      chk($sformatf("reset mem%0d", k), {mem_addr[k], mem_wdata[k]}, 48'd0);
      chk($sformatf("reset rdata%0d", k), {if_rdata[k], d_rdata[k]}, 64'd0);
    end

    // Simultaneous requests right after reset: data wins the first tie.
    poke(0, 8'h30, 32'h3030_0001);
    poke(0, 8'h31, 32'h3131_0002);
    if_req[0] = 1'b1; if_addr[0] = 16'h0031;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0030;
    watch(0, 12, -1, '0);
    chk("tie1 d_ack", w_dack, 3);
    chk("tie1 if_ack", w_iack, 7);
    chk("tie1 mem_en", {w_men0[7:0], w_men1[7:0], w_men_n[7:0]}, {8'd1, 8'd5, 8'd2});
    chk("tie1 overlap", w_ovl, 0);
    chk("tie1 rdata", {if_rdata[0], d_rdata[0]}, {32'h3131_0002, 32'h3030_0001});
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0032; d_wdata[0] = 32'h3232_3232;
    watch(0, 5, -1, '0);
    model_mem[0][8'h32] = 32'h3232_3232;
    chk("lone write d_ack", w_dack, 2);
    if_req[0] = 1'b1; if_addr[0] = 16'h0030;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0031;
    watch(0, 12, -1, '0);
    chk("tie2 if_ack", w_iack, 3);
    chk("tie2 d_ack", w_dack, 7);
    chk("tie2 overlap", w_ovl, 0);
    chk("tie2 rdata", {if_rdata[0], d_rdata[0]}, {32'h3030_0001, 32'h3131_0002});

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in cycle 2 of a MEM_LAT=3 read, then reissue.
    poke(1, 8'h09, 32'h9999_0009);
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 16'h0009;
    tick(); tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0; d_req[1] = 1'b0;
    chk("midrst ctl", outs_ctl(1), 5'd0);
    chk("midrst mem", {mem_addr[1], mem_wdata[1]}, 48'd0);
    chk("midrst rdata", {if_rdata[1], d_rdata[1]}, 64'd0);
    watch(1, 10, -1, '0);
    chk("midrst no_ack", {w_nd[7:0], w_ni[7:0], w_men_n[7:0]}, 24'd0);
    v5 = '{1, 1'b1, 1'b0, 16'h0009, 32'h0, 1'b0, 32'h0, 5, 32'h9999_0009};
    run_vec(8, v5);

    // Fetch raised while a data read waits: issue spacing MEM_LAT+3.
    v6a = 32'h6A6A_0001; v6b = 32'h6B6B_0002;
    poke(1, 8'h0A, v6a);
    poke(1, 8'h0B, v6b);
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 16'h000A;
    watch(1, 16, 3, 16'h000B);
    chk("busy d_ack", w_dack, 5);
    chk("busy if_ack", w_iack, 6 + LAT1 + 2);
    chk("busy spacing", w_men1 - w_men0, LAT1 + 3);
    chk("busy first_en", w_men0, 1);
    chk("busy rdata", {if_rdata[1], d_rdata[1]}, {v6b, v6a});

    // Randomized traffic against a transaction-level schedule model.
    for (int k = 0; k < 2; k++) begin
      do_reset(k);
      n = 0; m_free = 0; m_last = 0; g_grant = -10; g_issue = -10; g_ack = -10; g_port = 0;
      g_we = 1'b0; g_addr = '0; g_wd = '0; g_rd = '0;
      e_rd[0] = '0; e_rd[1] = '0; act[0] = 1'b0; act[1] = 1'b0;
      for (int it = 0; it < 300; it++) begin
        for (int q = 0; q < 2; q++) begin
          if (act[q] && n == g_ack && g_port == q) begin
            act[q] = 1'b0;
          end else if (!act[q] && $urandom_range(0, 2) == 0) begin
            act[q] = 1'b1;
            rq_addr[q] = 16'($urandom);
            rq_we[q] = (q == 1) ? 1'($urandom) : 1'b0;
            rq_wd[q] = $urandom;
          end
        end
        if_req[k] = act[0]; if_addr[k] = rq_addr[0];
        d_req[k] = act[1]; d_we[k] = rq_we[1]; d_addr[k] = rq_addr[1]; d_wdata[k] = rq_wd[1];
        if (n >= m_free && (act[0] || act[1])) begin
          if (act[0] && act[1]) p = (m_last == 0) ? 1 : 0;
          else p = act[1] ? 1 : 0;
          g_port = p; g_grant = n; g_issue = n + 1;
          g_we = rq_we[p]; g_addr = rq_addr[p]; g_wd = rq_wd[p];
          g_ack = n + 2 + (g_we ? 0 : lat_of(k));
          m_free = g_ack + 1; m_last = p;
          if (g_we) model_mem[k][g_addr[7:0]] = g_wd;
          else g_rd = model_mem[k][g_addr[7:0]];
        end
        tick();
        n++;
        if (n == g_ack && !g_we) e_rd[g_port] = g_rd;
        exp_ctl = {(n == g_ack) && (g_port == 0), (n == g_ack) && (g_port == 1),
                   (n == g_issue), (n == g_issue) && g_we, (n > g_grant) && (n <= g_ack)};
        chk($sformatf("rand%0d ctl n=%0d", k, n), outs_ctl(k), exp_ctl);
        chk($sformatf("rand%0d rdata n=%0d", k, n), {if_rdata[k], d_rdata[k]}, {e_rd[0], e_rd[1]});
        if (n == g_issue) begin
          chk($sformatf("rand%0d addr n=%0d", k, n), mem_addr[k], g_addr);
          if (g_we) chk($sformatf("rand%0d wdata n=%0d", k, n), mem_wdata[k], g_wd);
        end
      end
      if_req[k] = 1'b0; d_req[k] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
